// File: rtl/adc_capture_pkg.sv
// adc_capture_pkg: shared encodings for the ADC capture controller.
package adc_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TRIG = 2'd1,
    ST_CAPTURE   = 2'd2,
    ST_DONE      = 2'd3
  } state_e;

  localparam logic [1:0] MODE_CONT  = 2'd0;
  localparam logic [1:0] MODE_BURST = 2'd1;
  localparam logic [1:0] MODE_TRIG  = 2'd2;

  localparam int OVF_W = 16;

  // Mode 3 is an alias of fixed-length burst.
  function automatic logic [1:0] norm_mode(input logic [1:0] mode);
    return (mode == 2'd3) ? MODE_BURST : mode;
  endfunction

endpackage

// File: rtl/adc_capture_trig.sv
// adc_capture_trig: signed rising threshold-crossing detector on channel 0.
// Fires when the previous eligible sample was below the threshold and the
// current one is at or above it; the first sample after clear only primes
// the history.
module adc_capture_trig
  import adc_capture_pkg::*;
#(
  parameter int SAMPLE_W = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clear_i,
  input  logic                       sample_en_i,
  input  logic signed [SAMPLE_W-1:0] cur_i,
  input  logic signed [SAMPLE_W-1:0] thresh_i,
  output logic                       hit_o
);

  logic signed [SAMPLE_W-1:0] prev_q;
  logic                       prev_vld_q;

  assign hit_o = sample_en_i && prev_vld_q && (prev_q < thresh_i) && (thresh_i <= cur_i);

  // Keep the last eligible channel-0 sample; forget it on a new arm.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
    end else if (clear_i) begin
      prev_vld_q <= 1'b0;
    end else if (sample_en_i) begin
      prev_q     <= cur_i;
      prev_vld_q <= 1'b1;
    end
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: packs NUM_CH ADC channels into FIFO words and generates
// the FIFO write strobe for continuous, burst and triggered-burst capture,
// with decimation and overflow accounting.
// Optional feature: define ADC_CAPTURE_TESTPAT_EN to add the cfg_testpat
// input, which replaces written data with a per-lane ramp pattern.
module adc_capture_ctrl
  import adc_capture_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int SAMPLE_W = 16,
  parameter int COUNT_W  = 24,
  parameter int DECIM_W  = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       arm,
  input  logic                       abort,
  input  logic [1:0]                 cfg_mode,
  input  logic [COUNT_W-1:0]         cfg_burst_len,
  input  logic [DECIM_W-1:0]         cfg_decim,
  input  logic [SAMPLE_W-1:0]        cfg_thresh,
`ifdef ADC_CAPTURE_TESTPAT_EN
  input  logic                       cfg_testpat,
`endif
  input  logic [NUM_CH*SAMPLE_W-1:0] adc_data,
  input  logic                       adc_valid,
  input  logic                       src_rdy,
  input  logic                       fifo_prog_full,
  input  logic                       fifo_rst_busy,
  output logic                       fifo_wr_en,
  output logic [NUM_CH*SAMPLE_W-1:0] fifo_din,
  output logic                       busy,
  output logic                       done,
  output logic [OVF_W-1:0]           overflow_cnt,
  output logic [1:0]                 state_o
);

  localparam int DATA_W = NUM_CH * SAMPLE_W;

  state_e                     state_q;
  logic [1:0]                 mode_q;
  logic [COUNT_W-1:0]         burst_len_q, wr_cnt_q, wr_cnt_d;
  logic [DECIM_W-1:0]         decim_q, decim_cnt_q, decim_cnt_d;
  logic signed [SAMPLE_W-1:0] thresh_q;
  logic [OVF_W-1:0]           ovf_q;
  logic                       wr_en_q;
  logic [DATA_W-1:0]          din_q, wr_data;
`ifdef ADC_CAPTURE_TESTPAT_EN
  logic                       testpat_q;
  logic [SAMPLE_W-1:0]        ramp_q;
`endif

  logic [1:0] arm_mode;
  logic       arm_ok, arm_zero_len, eligible, trig_hit;
  logic       advance, candidate, fifo_ok, do_write, do_drop, burst_end;

  assign arm_mode     = norm_mode(cfg_mode);
  assign arm_ok       = arm && !abort && (state_q == ST_IDLE || state_q == ST_DONE);
  assign arm_zero_len = (arm_mode != MODE_CONT) && (cfg_burst_len == '0);
  assign eligible     = adc_valid && src_rdy;

  // The trigger sample itself is the first capture candidate; the decimation
  // counter is still zero there because arm cleared it.
  assign advance   = (state_q == ST_CAPTURE && eligible) || trig_hit;
  assign candidate = (state_q == ST_CAPTURE && eligible && decim_cnt_q == '0) || trig_hit;
  assign fifo_ok   = !fifo_prog_full && !fifo_rst_busy;
  assign do_write  = candidate && fifo_ok;
  assign do_drop   = candidate && !fifo_ok;

  assign decim_cnt_d = (decim_cnt_q == decim_q) ? '0 : decim_cnt_q + DECIM_W'(1);
  assign wr_cnt_d    = wr_cnt_q + COUNT_W'(1);
  assign burst_end   = do_write && (mode_q != MODE_CONT) && (wr_cnt_d == burst_len_q);

  adc_capture_trig #(
    .SAMPLE_W (SAMPLE_W)
  ) u_trig (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear_i     (arm_ok),
    .sample_en_i (eligible && state_q == ST_WAIT_TRIG),
    .cur_i       ($signed(adc_data[SAMPLE_W-1:0])),
    .thresh_i    (thresh_q),
    .hit_o       (trig_hit)
  );

  // Select the word to write: live samples or the lane-offset ramp.
  always_comb begin
    // NOTE: default assignment first so no path leaves wr_data unassigned (no latch).
    wr_data = adc_data;
`ifdef ADC_CAPTURE_TESTPAT_EN
    if (testpat_q) begin
      for (int k = 0; k < NUM_CH; k++) begin
        wr_data[k*SAMPLE_W +: SAMPLE_W] = ramp_q + SAMPLE_W'(k);
      end
    end
`endif
  end

  // Capture FSM with registered write strobe/data and counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_CONT;
      burst_len_q <= '0;
      decim_q     <= '0;
      thresh_q    <= '0;
      wr_cnt_q    <= '0;
      decim_cnt_q <= '0;
      ovf_q       <= '0;
      wr_en_q     <= 1'b0;
      din_q       <= '0;
`ifdef ADC_CAPTURE_TESTPAT_EN
      testpat_q   <= 1'b0;
      ramp_q      <= '0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      if (abort) begin
        state_q <= ST_IDLE;
      end else if (arm_ok) begin
        mode_q      <= arm_mode;
        burst_len_q <= cfg_burst_len;
        decim_q     <= cfg_decim;
        thresh_q    <= $signed(cfg_thresh);
        wr_cnt_q    <= '0;
        decim_cnt_q <= '0;
        ovf_q       <= '0;
`ifdef ADC_CAPTURE_TESTPAT_EN
        testpat_q   <= cfg_testpat;
        ramp_q      <= '0;
`endif
        if (arm_zero_len)            state_q <= ST_DONE;
        else if (arm_mode == MODE_TRIG) state_q <= ST_WAIT_TRIG;
        else                         state_q <= ST_CAPTURE;
      end else begin
        if (advance) decim_cnt_q <= decim_cnt_d;
        if (do_write) begin
          wr_en_q  <= 1'b1;
          din_q    <= wr_data;
          wr_cnt_q <= wr_cnt_d;
`ifdef ADC_CAPTURE_TESTPAT_EN
          ramp_q   <= ramp_q + SAMPLE_W'(1);
`endif
        end
        if (do_drop && ovf_q != '1) ovf_q <= ovf_q + OVF_W'(1);
        if (burst_end)     state_q <= ST_DONE;
        else if (trig_hit) state_q <= ST_CAPTURE;
      end
    end
  end

  assign fifo_wr_en   = wr_en_q;
  assign fifo_din     = din_q;
  assign busy         = (state_q == ST_WAIT_TRIG) || (state_q == ST_CAPTURE);
  assign done         = (state_q == ST_DONE);
  assign overflow_cnt = ovf_q;
  assign state_o      = state_q;

endmodule
